layer_0_conv_sequencer: RTL
===========================

// Module: layer_0_conv_sequencer
// PURPOSE
//  Frame-level controller for the layer-0 3x3 convolution featuremap bank.
//  On start: raster-reads one 3-channel image from the input buffer and streams it to all
//  featuremap instances in parallel. Counts their valid_out pulses, then signals done.
//  Sits between the input pixel RAM and the NUM_FMAPS featuremap blocks.
// PARAMETERS
//  DATA_WIDTH  96      packed pixel width (3 channels x 32-bit float, ch0 in [31:0])
//  IMG_SIZE    416     input image width = height, in pixels
//  ADDR_WIDTH  18      pixel RAM address width; must satisfy 2**ADDR_WIDTH >= IMG_SIZE**2
//  NUM_FMAPS   16      number of featuremap instances driven/monitored
// PORTS
//  Clk           in   1           clock, rising edge
//  Rst           in   1           asynchronous reset, active-high
//  start         in   1           1-cycle pulse; begins a frame when idle
//  out_ready     in   1           downstream can accept; 0 pauses pixel issue
//  rd_en         out  1           pixel RAM read strobe
//  rd_addr       out  ADDR_WIDTH  pixel RAM address, row*IMG_SIZE+col
//  rd_data       in   DATA_WIDTH  RAM data, valid 1 cycle after rd_en
//  fm_data_in    out  DATA_WIDTH  pixel broadcast to all featuremaps
//  fm_valid_in   out  1           qualifies fm_data_in
//  fm_valid_out  in   NUM_FMAPS   valid_out of each featuremap
//  busy          out  1           high from accepted start until done
//  done          out  1           1-cycle pulse at frame completion
//  err           out  1           sticky: fm_valid_out bits disagreed; cleared by next start
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; row/col/out counters 0. Rst mid-frame aborts immediately.
//  FSM: IDLE -start-> ISSUE -last position issued-> DRAIN -out count hit-> DONE -> IDLE.
//  IDLE: start sampled high -> clear counters and err, busy=1 next cycle.
//  start while not IDLE is ignored.
//  ISSUE: one scan position per cycle while out_ready=1. Raster order, col fastest.
//   out_ready=0: no issue and counters hold. Already-issued reads still complete.
//   Image position: rd_en=1, rd_addr=row*IMG_SIZE+col.
//   Address is an incrementing counter, not a multiply.
//  Pipeline: fm_valid_in and fm_data_in are registered one cycle after the issue cycle.
//   Fixed latency 1.
//   fm_data_in=rd_data for read positions; 0 for pad positions (see CONFIGURATION).
//  Output count: increments on fm_valid_out[0] in ISSUE or DRAIN.
//   Target OUT_N = (IMG_SIZE-2)**2 without padding, IMG_SIZE**2 with padding.
//   When count reaches OUT_N in ISSUE, the FSM still finishes ISSUE, then leaves DRAIN
//   on its first cycle.
//  DRAIN: no reads; waits until count==OUT_N, then -> DONE.
//  DONE: done=1 for exactly 1 cycle, busy=0 from the same cycle; -> IDLE.
//  err: set in any cycle where fm_valid_out is neither all-0 nor all-1. Held until next start.
//  Counters wrap never: col resets at last column, row increments; last position ends ISSUE.
// CONFIGURATION
//  Macro CONV_SEQ_ZERO_PAD_EN.
//  Defined: scan covers (IMG_SIZE+2)x(IMG_SIZE+2) positions.
//   Border positions (row/col 0 or IMG_SIZE+1) issue no read; fm_valid_in=1, fm_data_in=0.
//   Interior positions read address (row-1)*IMG_SIZE+(col-1). OUT_N=IMG_SIZE**2.
//  Undefined: scan covers IMG_SIZE x IMG_SIZE positions, all reads. OUT_N=(IMG_SIZE-2)**2.
// TESTING (IMG_SIZE=4, NUM_FMAPS=2, RAM model latency 1, featuremap models)
//  No pad, out_ready=1, start -> rd_addr 0..15 on consecutive cycles; 16 fm_valid_in;
//   after 4 fm_valid_out pulses, done pulses once and busy falls.
//  Pad enabled -> 36 fm_valid_in, 16 rd_en, 20 zero pixels.
//   First interior read at scan position 7 is addr 0; done after 16 outputs.
//  out_ready toggled 1,0,0,1 every 4 cycles -> rd_addr sequence still 0..15 gapless, no dup.
//   fm_valid_in count=16.
//  start pulsed again mid-frame -> ignored, addr sequence unchanged; one done only.
//  Rst asserted at rd_addr=7 -> next edge all outputs 0, busy=0.
//   Fresh start -> restart at addr 0.
//  fm_valid_out=2'b01 for one cycle -> err=1 held through done; cleared 1 cycle after next start.

Source files
------------

// File: rtl/layer_0_conv_sequencer.sv
// Frame sequencer for the layer-0 featuremap bank: raster-reads one image, broadcasts pixels,
// counts featuremap outputs and pulses done. Optional zero-padded scan via CONV_SEQ_ZERO_PAD_EN.
module layer_0_conv_sequencer #(
    parameter int DATA_WIDTH = 96,
    parameter int IMG_SIZE   = 416,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_FMAPS  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_out_ready,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_fm_data_in,
    output logic                  o_fm_valid_in,
    input  logic [NUM_FMAPS-1:0]  i_fm_valid_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

`ifdef CONV_SEQ_ZERO_PAD_EN
    localparam int SCAN  = IMG_SIZE + 2;
    localparam int OUT_N = IMG_SIZE * IMG_SIZE;
`else
    localparam int SCAN  = IMG_SIZE;
    localparam int OUT_N = (IMG_SIZE - 2) * (IMG_SIZE - 2);
`endif
    localparam int POS_W = $clog2(SCAN);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [POS_W-1:0] LAST_POS   = POS_W'(SCAN - 1);
    localparam logic [CNT_W-1:0] OUT_TARGET = CNT_W'(OUT_N);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [POS_W-1:0]      r_row;
    logic [POS_W-1:0]      r_col;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      r_out_cnt;
    logic                  r_err;
    logic                  r_fm_valid;
    logic                  r_fm_read;

    logic w_start_acc;
    logic w_issue;
    logic w_rd_en;
    logic w_busy;
    logic w_done;
    logic w_last_pos;
    logic w_is_pad;
    logic w_mixed;
    logic w_out_pulse;

    assign w_last_pos = (r_row == LAST_POS) && (r_col == LAST_POS);

`ifdef CONV_SEQ_ZERO_PAD_EN
    assign w_is_pad = (r_row == '0) || (r_col == '0) || (r_row == LAST_POS) || (r_col == LAST_POS);
`else
    assign w_is_pad = 1'b0;
`endif

    assign w_mixed     = (i_fm_valid_out != {NUM_FMAPS{1'b0}}) &&
                         (i_fm_valid_out != {NUM_FMAPS{1'b1}});
    assign w_out_pulse = i_fm_valid_out[0] && ((r_state == S_ISSUE) || (r_state == S_DRAIN));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_issue      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_busy = 1'b1;
                if (i_out_ready) begin
                    w_issue = 1'b1;
                    if (w_last_pos) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_out_cnt == OUT_TARGET) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pad positions are issued (they still produce a zero pixel) but never touch the RAM.
    assign w_rd_en = w_issue && !w_is_pad;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_addr     <= '0;
            r_out_cnt  <= '0;
            r_err      <= 1'b0;
            r_fm_valid <= 1'b0;
            r_fm_read  <= 1'b0;
        end else begin
            r_fm_valid <= w_issue;
            r_fm_read  <= w_rd_en;
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_mixed) begin
                r_err <= 1'b1;
            end
            if (w_start_acc) begin
                r_row     <= '0;
                r_col     <= '0;
                r_addr    <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_issue && !w_last_pos) begin
                    if (r_col == LAST_POS) begin
                        r_col <= '0;
                        r_row <= r_row + POS_W'(1);
                    end else begin
                        r_col <= r_col + POS_W'(1);
                    end
                end
                if (w_rd_en) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                if (w_out_pulse) begin
                    r_out_cnt <= r_out_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_rd_en       = w_rd_en;
    assign o_rd_addr     = w_rd_en ? r_addr : '0;
    assign o_fm_valid_in = r_fm_valid;
    assign o_fm_data_in  = r_fm_read ? i_rd_data : '0;
    assign o_busy        = w_busy;
    assign o_done        = w_done;
    assign o_err         = r_err;

endmodule
